// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and helpers for the TRNG consumer arbiter
// Purpose: FSM state encoding, fault code values and an index-width helper.
// Ports: none (package).
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2,
        FAULT   = 2'd3
    } state_e;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_REP     = 2'b10;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Purpose: pick the first requesting index strictly after last_i, wrapping.
// Ports:
//   req_i  [N-1:0]  request vector
//   last_i [IW-1:0] index granted last time
//   gnt_o  [N-1:0]  one-hot grant
//   idx_o  [IW-1:0] granted index
//   any_o           at least one request present
module rr_pick
    import rng_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int            cand;
    logic [IW-1:0] cidx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        cidx  = '0;
        // Offsets 1..N visit last_i+1 first and last_i itself last.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            cidx = cand[IW-1:0];
            if (!any_o && req_i[cidx]) begin
                any_o       = 1'b1;
                idx_o       = cidx;
                gnt_o[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin sharing of one TRNG collector with health checks
// Purpose: grant one rng fetch per consumer request, deliver each word exactly once,
//          and latch a sticky fault on a repetition or fetch timeout.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  global enable; low aborts any in-flight fetch
//   fault_clr               pulse that leaves the FAULT state
//   cli_req  [NUM_REQ-1:0]  per-consumer level request
//   cli_ack  [NUM_REQ-1:0]  one-hot delivery pulse
//   cli_word [WIDTH-1:0]    delivered word, zero when no ack
//   rng_en, rng_req         controls to the rng collector
//   rng_word, rng_valid     word and valid from the rng collector
//   fault, fault_code       sticky fault flag and cause
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 4,
    parameter int TIMEOUT   = 64,
    parameter int REP_LIMIT = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               fault_clr,
    input  logic [NUM_REQ-1:0] cli_req,
    output logic [NUM_REQ-1:0] cli_ack,
    output logic [WIDTH-1:0]   cli_word,
    output logic               rng_en,
    output logic               rng_req,
    input  logic [WIDTH-1:0]   rng_word,
    input  logic               rng_valid,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int TW = idx_w(TIMEOUT);
    localparam int RW = idx_w(REP_LIMIT + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;      // rr pointer doubles as the granted index
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [RW-1:0]      rep_q, rep_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic [1:0]         code_q, code_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [RW-1:0]      rep_inc;
    logic               rep_hit;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i  (cli_req),
        .last_i (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Repetition count for the word on rng_word. Saturates so that a limit
    // reached during an aborted fetch still trips on the next equal word.
    always_comb begin
        rep_inc = RW'(1);
        if (prev_vld_q && (rng_word == prev_q)) begin
            rep_inc = (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);
        end
        rep_hit = (rep_inc >= REP_MAX);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        word_d     = word_q;
        tmo_d      = '0;
        rep_d      = rep_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        code_d     = code_q;
        unique case (state_q)
            IDLE: begin
                if (enable && pick_any) begin
                    state_d = GRANT;
                    ptr_d   = pick_idx;
                    gnt_d   = pick_gnt;
                end
            end
            GRANT: begin
                tmo_d = tmo_q + TW'(1);
                // Health registers track every fetched word, even when aborted.
                if (rng_valid) begin
                    rep_d      = rep_inc;
                    prev_d     = rng_word;
                    prev_vld_d = 1'b1;
                end
                if (!enable) begin
                    state_d = IDLE;
                    word_d  = '0;
                end else if (rng_valid) begin
                    if (rep_hit) begin
                        state_d = FAULT;
                        code_d  = FAULT_REP;
                        word_d  = '0;
                    end else begin
                        state_d = DELIVER;
                        word_d  = rng_word;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FAULT;
                    code_d  = FAULT_TIMEOUT;
                end
            end
            DELIVER: begin
                // Word leaves the register whether it was taken or discarded.
                state_d = IDLE;
                word_d  = '0;
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d    = IDLE;
                    code_d     = FAULT_NONE;
                    rep_d      = '0;
                    prev_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NUM_REQ - 1);
            gnt_q      <= '0;
            word_q     <= '0;
            tmo_q      <= '0;
            rep_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            code_q     <= FAULT_NONE;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            word_q     <= word_d;
            tmo_q      <= tmo_d;
            rep_q      <= rep_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            code_q     <= code_d;
        end
    end

    // Ack is combinational so a consumer that dropped its request, or a
    // disable, suppresses delivery within the same cycle.
    always_comb begin
        cli_ack  = '0;
        if ((state_q == DELIVER) && enable) begin
            cli_ack = gnt_q & cli_req;
        end
        cli_word = (|cli_ack) ? word_q : '0;
    end

    assign fault      = (state_q == FAULT);
    assign fault_code = code_q;
    assign rng_en     = enable & ~fault;
    assign rng_req    = (state_q == GRANT) & ~rng_valid;

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - scoreboard bench for rng_arbiter
module tb_rng_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       fault_clr;
    logic [3:0] cli_req;
    logic [3:0] cli_ack;
    logic [3:0] cli_word;
    logic       rng_en;
    logic       rng_req;
    logic [3:0] rng_word;
    logic       rng_valid;
    logic       fault;
    logic [1:0] fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] ack;
        logic [3:0] word;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    rng_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (4),
        .TIMEOUT   (64),
        .REP_LIMIT (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fault_clr  (fault_clr),
        .cli_req    (cli_req),
        .cli_ack    (cli_ack),
        .cli_word   (cli_word),
        .rng_en     (rng_en),
        .rng_req    (rng_req),
        .rng_word   (rng_word),
        .rng_valid  (rng_valid),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivery must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cli_ack !== 4'b0000) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack %b word %h expected no ack", cli_ack, cli_word);
            end else begin
                mon_e = sbq.pop_front();
                check("ack_vec", 32'(cli_ack), 32'(mon_e.ack));
                check("ack_word", 32'(cli_word), 32'(mon_e.word));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        fault_clr = 1'b0;
        cli_req   = 4'b0000;
        rng_valid = 1'b0;
        rng_word  = 4'h0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic push_exp(input int idx, input logic [3:0] w);
        exp_t e;
        e.ack  = 4'b0001 << idx;
        e.word = w;
        sbq.push_back(e);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        @(negedge clk);
        while (!rng_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rng_req_seen", 32'(rng_req), 32'd1);
    endtask

    // Act as the rng for one fetch; optionally expect delivery to idx.
    task automatic fetch(input int idx, input logic [3:0] w, input bit deliver, input int extra);
        wait_req();
        repeat (extra) @(negedge clk);
        cyc();
        if (deliver) push_exp(idx, w);
        rng_valid = 1'b1;
        rng_word  = w;
        cyc();
        rng_valid = 1'b0;
        if (deliver) begin
            cyc();
            cli_req[2'(idx)] = 1'b0;
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (req[2'(i)]) return i;
        end
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev_req, just_acked, w, mprev;
        int  mptr, g, delay, mrep, set_cd, clr_cd, n;
        bit  in_grant, mprev_vld, mfault;

        // 1: reset state and minimum latency
        do_reset();
        @(negedge clk);
        check("rst_ack", 32'(cli_ack), 0);
        check("rst_word", 32'(cli_word), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(fault_code), 0);
        check("rst_rng_req", 32'(rng_req), 0);
        check("rst_rng_en", 32'(rng_en), 1);
        cyc(); cli_req = 4'b0001;
        @(negedge clk); check("t1_idle", 32'(rng_req), 0);
        cyc(); @(negedge clk); check("t1_grant", 32'(rng_req), 1);
        cyc(); rng_valid = 1'b1; rng_word = 4'hA; push_exp(0, 4'hA);
        @(negedge clk); check("t1_req_capture", 32'(rng_req), 0);
        cyc(); rng_valid = 1'b0;
        @(negedge clk);
        check("t1_ack", 32'(cli_ack), 32'h1);
        check("t1_word", 32'(cli_word), 32'hA);
        cyc(); cli_req = 4'b0000;
        @(negedge clk);
        check("t1_word_after", 32'(cli_word), 0);
        check("t1_ack_after", 32'(cli_ack), 0);

        // 2: all consumers, round-robin order twice
        do_reset();
        cyc(); cli_req = 4'hF;
        for (int i = 0; i < 4; i++) fetch(i, 4'(i + 1), 1'b1, 0);
        cli_req = 4'hF;
        for (int i = 0; i < 4; i++) fetch(i, 4'(i + 6), 1'b1, i % 2);

        // 3: repetition fault and recovery
        cli_req = 4'b0010; fetch(1, 4'h5, 1'b1, 0);
        cli_req = 4'b0100; fetch(2, 4'h5, 1'b1, 0);
        cli_req = 4'b1000; fetch(3, 4'h5, 1'b0, 0);
        @(negedge clk);
        check("t3_fault", 32'(fault), 1);
        check("t3_code", 32'(fault_code), 2);
        check("t3_rng_en", 32'(rng_en), 0);
        check("t3_no_ack", 32'(cli_ack), 0);
        cyc(); fault_clr = 1'b1;
        @(negedge clk); check("t3_fault_hold", 32'(fault), 1);
        cyc(); fault_clr = 1'b0;
        @(negedge clk);
        check("t3_fault_clr", 32'(fault), 0);
        check("t3_code_clr", 32'(fault_code), 0);
        fetch(3, 4'h5, 1'b1, 0);

        // 4: timeout
        cli_req = 4'b0001;
        wait_req();
        n = 0;
        while (rng_req && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t4_grant_cycles", 32'(n), 64);
        check("t4_fault", 32'(fault), 1);
        check("t4_code", 32'(fault_code), 1);
        check("t4_rng_req", 32'(rng_req), 0);
        cyc(); rng_valid = 1'b1; rng_word = 4'hB;
        cyc(); rng_valid = 1'b0;
        @(negedge clk); check("t4_late_valid_fault", 32'(fault), 1);
        cyc(); fault_clr = 1'b1;
        cyc(); fault_clr = 1'b0;
        fetch(0, 4'hC, 1'b1, 2);

        // 5: requester withdraws during GRANT
        do_reset();
        cyc(); cli_req = 4'b0010;
        fetch(1, 4'hD, 1'b1, 0);
        cli_req = 4'b1100;
        wait_req();
        cyc(); cli_req[2] = 1'b0; rng_valid = 1'b1; rng_word = 4'hE;
        cyc(); rng_valid = 1'b0;
        @(negedge clk);
        check("t5_no_ack", 32'(cli_ack), 0);
        check("t5_word_zero", 32'(cli_word), 0);
        fetch(3, 4'hF, 1'b1, 0);

        // enable low with rng_valid aborts the fetch
        cli_req = 4'b0001;
        wait_req();
        cyc(); enable = 1'b0; rng_valid = 1'b1; rng_word = 4'h7;
        cyc(); rng_valid = 1'b0;
        @(negedge clk);
        check("abort_rng_en", 32'(rng_en), 0);
        check("abort_no_ack", 32'(cli_ack), 0);
        cyc(); enable = 1'b1;
        fetch(0, 4'h8, 1'b1, 0);

        // 6: async reset in DELIVER
        cli_req = 4'b0001;
        wait_req();
        cyc(); rng_valid = 1'b1; rng_word = 4'h2; push_exp(0, 4'h2);
        cyc(); rng_valid = 1'b0;
        @(negedge clk);
        check("t6_ack_before", 32'(cli_ack), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_ack_async", 32'(cli_ack), 0);
        check("t6_word_async", 32'(cli_word), 0);
        check("t6_fault_async", 32'(fault), 0);
        @(posedge clk); #1;
        cli_req = 4'b0000;
        reset_n = 1'b1;

        // Randomized traffic against a reference model
        do_reset();
        mptr = 3; g = -1; delay = 0; mrep = 0; set_cd = 0; clr_cd = 0;
        in_grant = 0; mprev_vld = 0; mfault = 0; mprev = 4'h0;
        prev_req = 4'b0000;
        for (int cy = 0; cy < 3000; cy++) begin
            @(negedge clk);
            if (set_cd > 0) begin set_cd--; if (set_cd == 0) mfault = 1; end
            if (clr_cd > 0) begin clr_cd--; if (clr_cd == 0) mfault = 0; end
            check("rnd_fault", 32'(fault), 32'(mfault));
            if (mfault) check("rnd_code", 32'(fault_code), 2);
            if (rng_req && !in_grant) begin
                g = pick(prev_req, mptr);
                if (g < 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rnd_grant: got grant with request vector %b expected none", prev_req);
                end else begin
                    mptr = g; in_grant = 1; delay = $urandom_range(0, 2);
                end
            end
            just_acked = cli_ack;
            prev_req   = cli_req;
            @(posedge clk); #1;
            rng_valid = 1'b0;
            fault_clr = 1'b0;
            if (in_grant) begin
                if (delay == 0) begin
                    w = 4'($urandom_range(0, 3));
                    rng_valid = 1'b1;
                    rng_word  = w;
                    mrep = (mprev_vld && w == mprev) ? mrep + 1 : 1;
                    mprev = w; mprev_vld = 1;
                    if (mrep == 3) set_cd = 2;
                    else push_exp(g, w);
                    in_grant = 0;
                end else begin
                    delay--;
                end
            end
            if (mfault && clr_cd == 0 && set_cd == 0) begin
                fault_clr = 1'b1; clr_cd = 2; mprev_vld = 0; mrep = 0;
            end
            cli_req = cli_req & ~just_acked;
            if (cy < 2900) begin
                for (int i = 0; i < 4; i++) begin
                    if (!cli_req[2'(i)] && !just_acked[2'(i)] && $urandom_range(0, 3) == 0)
                        cli_req[2'(i)] = 1'b1;
                end
            end
        end
        repeat (10) @(negedge clk);
        check("sb_drain", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
Shares one TRNG word collector (the `rng` block: WIDTH-bit words, `req`/`output_valid` handshake) between NUM_REQ on-chip HSM consumers (keygen, nonce, masking).
Round-robin grants, one fetch per grant, exactly-once delivery of every word.
Runs a repetition-count health test on fetched words and a fetch timeout; either failure latches a sticky fault that blocks all consumers until cleared.

Parameters:
NUM_REQ, 4, number of consumer ports (2..8)
WIDTH, 4, random word width; must equal the rng instance WIDTH
TIMEOUT, 64, max cycles in GRANT without rng_valid before fault
REP_LIMIT, 3, consecutive identical words that trigger the repetition fault

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global enable; low = no new grants, abort in-flight fetch
fault_clr  in  1  one-cycle pulse; leaves FAULT
cli_req  in  NUM_REQ  per-consumer request, level, held until ack
cli_ack  out  NUM_REQ  one-hot one-cycle delivery pulse
cli_word  out  WIDTH  delivered word; valid only while any cli_ack bit is high, else 0
rng_en  out  1  to rng en
rng_req  out  1  to rng req
rng_word  in  WIDTH  from rng random_word
rng_valid  in  1  from rng output_valid
fault  out  1  sticky health/timeout fault
fault_code  out  2  00 none, 01 timeout, 10 repetition

Behaviour:
- Reset (async, reset_n low): state IDLE; cli_ack=0; cli_word=0; fault=0; fault_code=00; rr pointer=NUM_REQ-1; timeout and repetition counters=0; prev-word-valid=0.
- rng_en = enable & ~fault. The rng keeps pre-collecting bits while IDLE.
- rng_req = (state==GRANT) & ~rng_valid. This is combinational, so req is never high during the capture cycle.
- IDLE:
  - If enable and |cli_req: grant the first requesting index strictly after the rr pointer, wrapping.
  - Latch the grant index, load the pointer with it, and go to GRANT.
- GRANT:
  - The timeout counter increments each cycle.
  - On rng_valid: capture rng_word into the word register, then run the health check:
    - if prev-word-valid and rng_word==prev: rep_cnt+1, else rep_cnt=1;
    - prev=rng_word; prev-word-valid=1.
  - If the new rep_cnt==REP_LIMIT: go to FAULT with code 10 and zero the word (never delivered). Otherwise go to DELIVER.
  - If the counter reaches TIMEOUT-1 without rng_valid: go to FAULT with code 01.
  - rng_valid outside GRANT is ignored; that word is lost and never delivered.
- DELIVER:
  - If the granted consumer's cli_req is still high: pulse its cli_ack for 1 cycle, drive cli_word=word register, then zero the word register. Otherwise discard the word silently (never re-routed to another consumer).
  - Go to IDLE either way.
  - A consumer must deassert cli_req the cycle after its ack, or it re-arbitrates normally.
- FAULT:
  - fault=1, no grants, rng_en=0.
  - fault_clr: clear fault, fault_code, rep_cnt and prev-word-valid; go to IDLE.
  - fault_clr in any other state has no effect.
- Minimum latency:
  - cli_req seen in IDLE at cycle t: GRANT at t+1, rng_valid at t+2 (word ready), cli_ack at t+3.
  - Back-to-back grants are limited by the rng refill time of WIDTH cycles.
- enable low in GRANT or DELIVER: abort to IDLE next cycle, no ack, word register zeroed. The rr pointer keeps the aborted grant.
- Simultaneous rng_valid and timeout expiry in GRANT: rng_valid wins.
- Simultaneous enable low and rng_valid: abort wins, but the health-check registers still update.
- Fairness: a requester that holds cli_req waits at most NUM_REQ-1 other grants.

Decomposition:
- Package rng_pkg:
  - state enum {IDLE, GRANT, DELIVER, FAULT};
  - fault code constants FAULT_NONE/FAULT_TIMEOUT/FAULT_REP;
  - clog2-derived index-width helper.
- Sub-module rr_pick:
  - combinational round-robin selector;
  - inputs: req vector, last pointer;
  - outputs: one-hot grant, index, any.
- The FSM, counters and health check stay in rng_arbiter.

Test Plan:
1. Single consumer: cli_req=0001 after reset, rng_valid with rng_word=4'hA two cycles later → cli_ack=0001 and cli_word=4'hA exactly 3 cycles after req; cli_word=0 on the next cycle.
2. All consumers: cli_req=1111 held, each dropped after its ack → ack order 0,1,2,3; then re-raise 1111 → 0,1,2,3 again; no index acked twice in a row.
3. Repetition fault: rng returns 4'h5 three times → first two delivered; third causes fault=1, fault_code=10, no ack; rng_en=0; fault_clr → IDLE, and the next 4'h5 is delivered.
4. Timeout: grant with rng_valid held low 64 cycles → fault=1, fault_code=01, rng_req=0; a rng_valid arriving later is ignored.
5. Requester withdraws: cli_req[2] dropped while in GRANT → word captured, no cli_ack, cli_word stays 0; the next grant goes to index 3 if requesting.
6. reset_n asserted mid-DELIVER (async, between edges) → cli_ack=0, cli_word=0 and fault=0 immediately, without waiting for a clock edge.
